conv_post_proc: RTL and testbench
=================================

Name: conv_post_proc

Overview:
- Downstream stage of the 16-lane convolution compute array. Consumes the 16 signed 32-bit accumulator results once a convolution window completes.
- Per lane: adds bias, optionally applies ReLU, requantizes with a rounding arithmetic right shift, then saturates to signed 8-bit.
- Packs the 16 int8 results into one 128-bit word, in the same byte layout the compute array consumes, for write-back to the feature-map buffer.
- 3-stage valid/ready pipeline with full throughput and backpressure.

Parameters:
- LANES, 16, number of parallel lanes.
- ACC_W, 32, accumulator input width per lane (signed).
- BIAS_W, 16, bias width per lane (signed).
- OUT_W, 8, output width per lane (signed).
- SHIFT_W, 5, width of the requantization shift amount.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- acc_valid  in  1  accumulator beat valid.
- acc_ready  out  1  stage can accept a beat.
- acc_data  in  LANES*ACC_W  lane i at [i*32+:32], signed.
- bias_in  in  LANES*BIAS_W  lane i at [i*16+:16], signed; sampled with the beat.
- cfg_shift  in  SHIFT_W  right-shift amount; sampled with the beat.
- cfg_relu_en  in  1  ReLU enable; sampled with the beat.
- out_valid  out  1  packed result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  LANES*OUT_W  lane i at [i*8+:8], signed int8.
- sat_clr  in  1  clears the saturation counter (used only with the optional feature).
- sat_count  out  16  saturation event count (optional feature).

Behaviour:
- Reset (synchronous, active-high) clears all stage valid bits.
  - out_valid=0, out_data=0, sat_count=0.
  - acc_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation drops every in-flight beat; no partial output appears.
- Handshake:
  - Input transfer happens when acc_valid && acc_ready.
  - Output transfer happens when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - When stall=1, all stages hold and acc_ready=0. When stall=0, all stages advance and acc_ready=1.
  - Bubbles (invalid stages) also advance. out_data stays stable while out_valid && !out_ready.
- Latency: 3 cycles from input transfer to out_valid. Throughput: 1 beat per cycle. Beats emerge in order; none are dropped or duplicated.
- Configuration (cfg_shift, cfg_relu_en, bias_in) is captured with each beat in S1 and travels with it, so per-beat changes are legal.
- S1, bias add:
  - b = sign-extended bias_in lane; s1 = acc + b computed at ACC_W+1 bits.
  - Saturate to the ACC_W signed range [0x80000000, 0x7FFFFFFF].
- S2, ReLU and round-shift:
  - If relu_en and s1<0, then x=0; otherwise x=s1.
  - If shift==0, r=x. Otherwise r=(x + 2^(shift-1)) >>> shift, computed at ACC_W+1 bits so the rounding add cannot overflow.
- S3, saturate and pack:
  - Clip r to [-128,127] and pack.
  - A lane is "saturated" if clipping changed its value. S1 saturation does not count.

Optional Feature:
- Macro: CONV_POST_SAT_CNT_EN.
- Defined:
  - sat_count increments by the number of saturated lanes in each beat transferred out of S3 (0..16).
  - The counter saturates at 0xFFFF.
  - sat_clr=1 forces the count to 0 and takes priority over an increment in the same cycle.
- Undefined: sat_count is tied to 0, sat_clr is ignored, and no counter logic is generated.

Decomposition:
- Package conv_post_pkg holds:
  - Constants: LANES, ACC_W, BIAS_W, OUT_W, SHIFT_W, INT8_MAX=127, INT8_MIN=-128, ACC_MAX, ACC_MIN.
  - Typedef: per-lane stage record.
  - Functions: sat_acc, sat_int8.
- Sub-module conv_post_lane: one lane's S1/S2/S3 datapath registers with shared enable, instantiated LANES times.
- Handshake/valid control lives in the top level.

Test Plan:
- Rounding: acc=1000, bias=24, shift=4, relu=0 on all lanes -> 1024+8=1032, >>4 = 64; out_data = 16 bytes of 0x40, valid 3 cycles after input.
- ReLU and clip: acc=-300, bias=0, shift=1.
  - relu=1 -> lane = 0x00.
  - relu=0 -> (-300+1)>>>1 = -150, clipped to 0x80.
  - With CONV_POST_SAT_CNT_EN defined, sat_count goes 0 -> 16 only for the relu=0 beat.
- Overflow: acc=0x7FFFFFF0, bias=0x7FFF, shift=24 -> S1 saturates to 0x7FFFFFFF; (0x7FFFFFFF+0x800000)>>24 = 128 -> 0x7F; no wrap to negative.
- Backpressure: stream 6 beats with lane i = beat index k in lane i, shift=0; hold out_ready=0 for cycles 4-8.
  - acc_ready must drop while stalled, and out_data must stay stable.
  - All 6 beats must arrive in order, each with every lane = k, with none lost.
- Reset mid-stream: assert rst for 1 cycle while 3 beats are in flight -> next cycle out_valid=0, out_data=0, sat_count=0; a new beat then appears exactly 3 cycles after it is accepted.
- Counter limits: pre-load near 0xFFFF with repeated all-clip beats -> sat_count holds at 0xFFFF; sat_clr asserted in the same cycle as a clipping beat -> count = 0.

Source files
------------

// File: rtl/conv_post_pkg.sv
// Shared constants, record types and saturation helpers for the convolution
// post-processing stage (bias add, ReLU, rounding requantize, int8 clip).
package conv_post_pkg;

  localparam int LANES   = 16;
  localparam int ACC_W   = 32;
  localparam int BIAS_W  = 16;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit above the accumulator width: wide enough for acc+bias and
  // for the rounding add, so neither can overflow before saturation.
  typedef logic signed [ACC_W:0] wide_t;

  // Per-beat configuration, captured with the beat and carried along with it.
  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic               relu_en;
  } beat_cfg_t;

  // Per-lane final stage record: the int8 result plus its clip flag.
  typedef struct packed {
    logic [OUT_W-1:0] q;
    logic             sat;
  } lane_rec_t;

  // Clamp a guard-extended sum back into the signed accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input wide_t v);
    if (v[ACC_W] != v[ACC_W-1]) begin
      return v[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return v[ACC_W-1:0];
  endfunction

  // Clamp a requantized value into the signed int8 range.
  function automatic logic [OUT_W-1:0] sat_int8(input wide_t v);
    if (v > wide_t'(INT8_MAX)) begin
      return OUT_W'(INT8_MAX);
    end
    if (v < wide_t'(INT8_MIN)) begin
      return OUT_W'(INT8_MIN);
    end
    return v[OUT_W-1:0];
  endfunction

  // True when clamping to int8 would alter the value.
  function automatic logic int8_clips(input wide_t v);
    return (v > wide_t'(INT8_MAX)) || (v < wide_t'(INT8_MIN));
  endfunction

endpackage

// File: rtl/conv_post_lane.sv
// One lane of the post-processing datapath: S1 bias add with saturation,
// S2 ReLU and rounding arithmetic right shift, S3 int8 clip. All three
// stage registers share a single advance enable driven by the top level.
module conv_post_lane
  import conv_post_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ACC_W-1:0]   acc,
  input  logic [BIAS_W-1:0]  bias,
  input  logic [SHIFT_W-1:0] s1_shift,
  input  logic               s1_relu_en,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);

  logic signed [ACC_W-1:0] s1_q, s1_d;
  wide_t                   s2_q, s2_d;
  lane_rec_t               s3_q, s3_d;

  wide_t sum_w;
  wide_t x_w;
  wide_t rnd_w;

  // S1: sign-extend both operands to the guard width, add, clamp.
  always_comb begin
    sum_w = wide_t'({acc[ACC_W-1], acc})
          + wide_t'({{(ACC_W+1-BIAS_W){bias[BIAS_W-1]}}, bias});
    s1_d  = sat_acc(sum_w);
  end

  // S2: optional ReLU, then round-half-up arithmetic shift at guard width.
  always_comb begin
    x_w   = (s1_relu_en && s1_q[ACC_W-1]) ? '0 : wide_t'(s1_q);
    rnd_w = '0;
    s2_d  = x_w;
    if (s1_shift != '0) begin
      rnd_w = wide_t'(1) << (s1_shift - 1'b1);
      s2_d  = (x_w + rnd_w) >>> s1_shift;
    end
  end

  // S3: clip to int8 and flag whether the clip changed the value.
  always_comb begin
    s3_d.q   = sat_int8(s2_q);
    s3_d.sat = int8_clips(s2_q);
  end

  // Stage registers advance together; reset zeroes the visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign q   = s3_q.q;
  assign sat = s3_q.sat;

endmodule

// File: rtl/conv_post_proc.sv
// Convolution post-processing top: 16 lanes of bias/ReLU/requantize/clip
// behind a 3-stage valid/ready pipeline, packed into one 128-bit int8 word.
// Optional saturation-event counter enabled by defining CONV_POST_SAT_CNT_EN.
module conv_post_proc
  import conv_post_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_valid,
  output logic                     acc_ready,
  input  logic [LANES*ACC_W-1:0]   acc_data,
  input  logic [LANES*BIAS_W-1:0]  bias_in,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  input  logic                     sat_clr,
  output logic [15:0]              sat_count
);

  logic      v1_q, v1_d;
  logic      v2_q, v2_d;
  logic      v3_q, v3_d;
  beat_cfg_t cfg_q, cfg_d;
  logic      stall;
  logic      adv;
  logic [LANES-1:0] sat_vec;

  // The only thing that can hold the pipe is an unaccepted output word;
  // otherwise every stage, bubble or not, moves forward each cycle.
  assign stall     = v3_q && !out_ready;
  assign adv       = !stall;
  assign acc_ready = adv;
  assign out_valid = v3_q;

  // Next-state for stage valid bits and the per-beat configuration.
  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    cfg_d = cfg_q;
    if (adv) begin
      v1_d          = acc_valid;
      v2_d          = v1_q;
      v3_d          = v2_q;
      cfg_d.shift   = cfg_shift;
      cfg_d.relu_en = cfg_relu_en;
    end
  end

  // Stage valid bits and S1 configuration; reset discards in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      cfg_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      cfg_q <= cfg_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    conv_post_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .en         (adv),
      .acc        (acc_data[gi*ACC_W +: ACC_W]),
      .bias       (bias_in[gi*BIAS_W +: BIAS_W]),
      .s1_shift   (cfg_q.shift),
      .s1_relu_en (cfg_q.relu_en),
      .q          (out_data[gi*OUT_W +: OUT_W]),
      .sat        (sat_vec[gi])
    );
  end

`ifdef CONV_POST_SAT_CNT_EN
  localparam int CNT_W = 16;
  localparam int POP_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POP_W-1:0] pop_w;
  logic [CNT_W:0]   cnt_sum_w;

  // Count clipped lanes of each delivered word; clear wins over increment.
  always_comb begin
    pop_w = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_w = pop_w + POP_W'(sat_vec[i]);
    end
    cnt_sum_w = {1'b0, cnt_q} + (CNT_W+1)'(pop_w);
    cnt_d     = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (v3_q && out_ready) begin
      cnt_d = cnt_sum_w[CNT_W] ? '1 : cnt_sum_w[CNT_W-1:0];
    end
  end

  // Saturation event counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_count = cnt_q;
`else
  logic unused_sat;
  assign unused_sat = ^{sat_clr, sat_vec};
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_conv_post_proc.sv
module tb_conv_post_proc;

  logic         clk;
  logic         rst;
  logic         acc_valid;
  logic         acc_ready;
  logic [511:0] acc_data;
  logic [255:0] bias_in;
  logic [4:0]   cfg_shift;
  logic         cfg_relu_en;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         sat_clr;
  logic [15:0]  sat_count;

  conv_post_proc dut (
    .clk         (clk),
    .rst         (rst),
    .acc_valid   (acc_valid),
    .acc_ready   (acc_ready),
    .acc_data    (acc_data),
    .bias_in     (bias_in),
    .cfg_shift   (cfg_shift),
    .cfg_relu_en (cfg_relu_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sat_clr     (sat_clr),
    .sat_count   (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0] data;
    int           nsat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   exp_sat  = 0;
  bit   rdone;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  // Reference: straight integer arithmetic on each lane.
  function automatic exp_t model(input logic [511:0] a, input logic [255:0] b,
                                 input int sh, input bit relu);
    exp_t   e;
    longint s;
    longint bb;
    e.data = '0;
    e.nsat = 0;
    for (int i = 0; i < 16; i++) begin
      s  = $signed(a[i*32 +: 32]);
      bb = $signed(b[i*16 +: 16]);
      s  = s + bb;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (relu && s < 0) s = 0;
      if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
      if (s > 127) begin s = 127; e.nsat++; end
      else if (s < -128) begin s = -128; e.nsat++; end
      e.data[i*8 +: 8] = s[7:0];
    end
    return e;
  endfunction

  function automatic logic [511:0] rep_acc(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [255:0] rep_bias(input logic [15:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  // Input monitor: expected response pushed at every accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) exp_q.delete();
      else if (acc_valid && acc_ready)
        exp_q.push_back(model(acc_data, bias_in, int'(cfg_shift), cfg_relu_en));
    end
  end

  // Output monitor: pops and compares on every delivered word.
  initial begin
    exp_t         e;
    logic         prev_stall;
    logic [127:0] prev_data;
    int           nsat;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      nsat = 0;
      if (rst) begin
        prev_stall = 1'b0;
        exp_sat    = 0;
      end else begin
        chk("acc_ready", acc_ready, !(out_valid && !out_ready));
        chk("sat_count", sat_count, exp_sat);
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            nsat = e.nsat;
            chk("out_data", out_data, e.data);
            $display("out beat %0d data=%h clipped_lanes=%0d", n_out, out_data, e.nsat);
            n_out++;
          end
        end
`ifdef CONV_POST_SAT_CNT_EN
        if (sat_clr) exp_sat = 0;
        else if (out_valid && out_ready) exp_sat = (exp_sat + nsat > 65535) ? 65535 : exp_sat + nsat;
`endif
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic send(input logic [511:0] a, input logic [255:0] b,
                      input logic [4:0] sh, input logic relu);
    int   guard;
    logic took;
    guard = 0;
    took  = 1'b0;
    acc_data = a; bias_in = b; cfg_shift = sh; cfg_relu_en = relu; acc_valid = 1'b1;
    while (!took && guard < 500) begin
      @(negedge clk);
      took = acc_ready;
      guard++;
    end
    if (!took) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    acc_valid = 1'b0;
  endtask

  task automatic measure_latency(input string nm, input int req);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk(nm, lat, req);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [511:0] a;
    logic [255:0] b;
    int           v;
    rst = 1'b1; acc_valid = 1'b0; acc_data = '0; bias_in = '0;
    cfg_shift = '0; cfg_relu_en = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_sat_count", sat_count, 16'h0);
    chk("rst_acc_ready", acc_ready, 1'b1);
    @(posedge clk); #1;

    // Rounding: (1000+24+8)>>4 = 64 on every lane, 3-cycle latency.
    send(rep_acc(32'd1000), rep_bias(16'd24), 5'd4, 1'b0);
    measure_latency("latency_round", 3);
    chk("round_word", out_data, {16{8'h40}});
    drain();

    // ReLU zeroes a negative lane; without ReLU -150 clips to -128.
    send(rep_acc(-32'sd300), rep_bias(16'd0), 5'd1, 1'b1);
    send(rep_acc(-32'sd300), rep_bias(16'd0), 5'd1, 1'b0);
    drain();

    // S1 saturation must not wrap negative.
    send(rep_acc(32'h7FFFFFF0), rep_bias(16'h7FFF), 5'd24, 1'b0);
    measure_latency("latency_ovf", 3);
    chk("ovf_word", out_data, {16{8'h7F}});
    drain();

    // Backpressure: 6 beats, consumer stalls for a window mid-stream.
    fork
      begin
        for (int k = 0; k < 6; k++) send(rep_acc(k), rep_bias(16'd0), 5'd0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) send(rep_acc(10 + k), rep_bias(16'd0), 5'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 128'h0);
    chk("midrst_sat_count", sat_count, 16'h0);
    @(posedge clk); #1;
    send(rep_acc(32'd77), rep_bias(16'd0), 5'd0, 1'b0);
    measure_latency("latency_after_rst", 3);
    drain();

    // Random beats with random consumer readiness.
    rdone = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
              0: v = int'($urandom);
              1: v = int'($urandom_range(0, 4000)) - 2000;
              default: v = $urandom_range(0, 1) ? 32'h7FFFFF00 + $urandom_range(0, 255)
                                                : 32'h80000000 + $urandom_range(0, 255);
            endcase
            a[i*32 +: 32] = v;
            b[i*16 +: 16] = 16'($urandom);
          end
          send(a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef CONV_POST_SAT_CNT_EN
    // Counter ceiling: 4100 fully clipping beats exceed 0xFFFF events.
    for (int n = 0; n < 4100; n++) send(rep_acc(-32'sd300), rep_bias(16'd0), 5'd1, 1'b0);
    drain();
    chk("sat_ceiling", sat_count, 16'hFFFF);
    // Clear in the same cycle a clipping beat is delivered.
    send(rep_acc(-32'sd300), rep_bias(16'd0), 5'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    @(negedge clk);
    chk("sat_clr_priority", sat_count, 16'h0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
